// File: rtl/pipelined_addsub_if.sv
// Handshake and data bundle for the pipelined adder/subtractor.
// The slave side is the arithmetic block; the master side issues operations and takes results.
interface pipelined_addsub_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned TAG_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_sub;
    logic [TAG_W-1:0] in_tag;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             out_cout;
    logic             out_ovf;
    logic             out_ne;
    logic             out_lt;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_a, in_b, in_sub, in_tag, out_ready,
        input  in_ready, out_valid, out_result, out_cout, out_ovf, out_ne, out_lt, out_tag
    );

    modport slave (
        input  in_valid, in_a, in_b, in_sub, in_tag, out_ready,
        output in_ready, out_valid, out_result, out_cout, out_ovf, out_ne, out_lt, out_tag
    );
endinterface

// File: rtl/pipelined_addsub.sv
// Pipelined WIDTH-bit adder/subtractor: one CHUNK-bit slice per stage, carry registered between
// stages, valid/ready handshake with a single global advance enable (bubbles are not collapsed).
// The last stage register doubles as the output register and carries the compare flags.
module pipelined_addsub #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CHUNK = 8,
    parameter int unsigned TAG_W = 4
) (
    input logic          clock,
    input logic          reset,
    pipelined_addsub_if.slave bus
);
    localparam int unsigned STAGES = WIDTH / CHUNK;
    localparam int unsigned LAST   = STAGES - 1;

    // Stage registers. Operands shift right by CHUNK each stage so the live slice is always at
    // bit 0; result slices enter from the top so slice 0 lands at bit 0 after the last stage.
    logic             valid_q [STAGES];
    logic [WIDTH-1:0] res_q   [STAGES];
    logic [WIDTH-1:0] a_q     [STAGES];
    logic [WIDTH-1:0] b_q     [STAGES];
    logic             carry_q [STAGES];
    logic [TAG_W-1:0] tag_q   [STAGES];
    logic             ovf_q;
    logic             ne_q;
    logic             lt_q;

    // Per-stage inputs (previous stage register, or the new operation for stage 0).
    logic             src_valid [STAGES];
    logic [WIDTH-1:0] src_res   [STAGES];
    logic [WIDTH-1:0] src_a     [STAGES];
    logic [WIDTH-1:0] src_b     [STAGES];
    logic             src_carry [STAGES];
    logic [TAG_W-1:0] src_tag   [STAGES];

    logic [CHUNK:0]       sum     [STAGES];
    logic [WIDTH+CHUNK-1:0] res_cat [STAGES];
    logic [WIDTH-1:0]     res_d   [STAGES];

    logic en;
    logic carry_msb;
    logic ovf_d;
    logic ne_d;
    logic lt_d;

    assign en = !valid_q[LAST] || bus.out_ready;

    // Select each stage's source: new operation for stage 0, previous register otherwise.
    always_comb begin
        src_valid[0] = bus.in_valid && en;
        src_res[0]   = '0;
        src_a[0]     = bus.in_a;
        src_b[0]     = bus.in_sub ? ~bus.in_b : bus.in_b;
        src_carry[0] = bus.in_sub;
        src_tag[0]   = bus.in_tag;
        for (int unsigned k = 1; k < STAGES; k++) begin
            src_valid[k] = valid_q[k-1];
            src_res[k]   = res_q[k-1];
            src_a[k]     = a_q[k-1];
            src_b[k]     = b_q[k-1];
            src_carry[k] = carry_q[k-1];
            src_tag[k]   = tag_q[k-1];
        end
    end

    // Slice adders and the result shift for every stage.
    always_comb begin
        for (int unsigned k = 0; k < STAGES; k++) begin
            sum[k] = {1'b0, src_a[k][CHUNK-1:0]} + {1'b0, src_b[k][CHUNK-1:0]}
                   + {{CHUNK{1'b0}}, src_carry[k]};
            res_cat[k] = {sum[k][CHUNK-1:0], src_res[k]};
            res_d[k]   = res_cat[k][WIDTH+CHUNK-1:CHUNK];
        end
    end

    // Flags from the final stage; carry into the MSB recovered from the MSB sum bit.
    always_comb begin
        carry_msb = sum[LAST][CHUNK-1] ^ src_a[LAST][CHUNK-1] ^ src_b[LAST][CHUNK-1];
        ovf_d     = carry_msb ^ sum[LAST][CHUNK];
        ne_d      = |res_d[LAST];
        lt_d      = res_d[LAST][WIDTH-1] ^ ovf_d;
    end

    // Pipeline advance: everything shifts together on en, holds otherwise.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                valid_q[k] <= 1'b0;
                res_q[k]   <= '0;
                a_q[k]     <= '0;
                b_q[k]     <= '0;
                carry_q[k] <= 1'b0;
                tag_q[k]   <= '0;
            end
            ovf_q <= 1'b0;
            ne_q  <= 1'b0;
            lt_q  <= 1'b0;
        end else if (en) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                valid_q[k] <= src_valid[k];
                res_q[k]   <= res_d[k];
                a_q[k]     <= src_a[k] >> CHUNK;
                b_q[k]     <= src_b[k] >> CHUNK;
                carry_q[k] <= sum[k][CHUNK];
                tag_q[k]   <= src_tag[k];
            end
            ovf_q <= ovf_d;
            ne_q  <= ne_d;
            lt_q  <= lt_d;
        end
    end

    assign bus.in_ready   = en;
    assign bus.out_valid  = valid_q[LAST];
    assign bus.out_result = res_q[LAST];
    assign bus.out_cout   = carry_q[LAST];
    assign bus.out_ovf    = ovf_q;
    assign bus.out_ne     = ne_q;
    assign bus.out_lt     = lt_q;
    assign bus.out_tag    = tag_q[LAST];
endmodule
